// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit: a Moore FSM with registered per-state controls.
// Only the FETCH handshake strobes (mem_ready), pc_en (zero) and reset gating are combinational.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctr,
  output logic       ext_op,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b001;

  // fetch marks the state whose ir_write/pc_write follow mem_ready
  typedef struct packed {
    logic       jump_wr;
    logic       br_wr;
    logic       fetch;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctr;
    logic       ext_op;
  } ctl_t;

  function automatic ctl_t ctl_default();
    ctl_t c;
    c         = '0;
    c.alu_ctr = ALU_ADD;
    c.ext_op  = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ctl_of(input state_e st, input logic [5:0] fn);
    ctl_t c;
    c = ctl_default();
    case (st)
      S_FETCH:    begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_R_EXE:    begin
        c.alu_src_a = 1'b1;
        c.alu_ctr   = (fn == F_SUBU) ? ALU_SUB : ALU_ADD;
      end
      S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH:   begin
        c.alu_src_a = 1'b1;
        c.alu_ctr   = ALU_SUB;
        c.br_wr     = 1'b1;
        c.pc_src    = 2'b01;
      end
      S_JUMP:     begin c.jump_wr = 1'b1; c.pc_src = 2'b10; end
      S_I_EXE:    begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b0;
        c.alu_ctr   = ALU_OR;
      end
      S_I_WB:     c.reg_write = 1'b1;
      default:    c = ctl_default();
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [5:0] op_q, funct_q;
  logic       illegal_q;
  logic       bad_d;
  logic [5:0] funct_sel_d;
  ctl_t       ctl_q, ctl_d, ctl_s;
  logic       fetch_go_s;

  // next-state decode; MEM_ADDR steers on the opcode captured when DECODE was left
  always_comb begin
    state_d = state_q;
    bad_d   = 1'b0;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_RTYPE) && ((funct == F_ADDU) || (funct == F_SUBU))) begin
          state_d = S_R_EXE;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_d = S_MEM_ADDR;
        end else if (op == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (op == OP_J) begin
          state_d = S_JUMP;
        end else if (op == OP_ORI) begin
          state_d = S_I_EXE;
        end else begin
          state_d = S_FETCH;
          bad_d   = 1'b1;
        end
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXE:    state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_I_EXE:    state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    funct_sel_d = (state_q == S_DECODE) ? funct : funct_q;
    ctl_d       = ctl_of(state_d, funct_sel_d);
  end

  // state, instruction latch, sticky flag and controls for the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
      ctl_q     <= ctl_of(S_FETCH, 6'd0);
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | bad_d;
      ctl_q     <= ctl_d;
      if (state_q == S_DECODE) begin
        op_q    <= op;
        funct_q <= funct;
      end
    end
  end

  // while reset is held every control sits at its quiet default
  always_comb begin
    if (rst_n) begin
      ctl_s = ctl_q;
    end else begin
      ctl_s = ctl_default();
    end
  end

  assign fetch_go_s    = ctl_s.fetch & mem_ready;
  assign pc_write      = ctl_s.jump_wr | fetch_go_s;
  assign pc_write_cond = ctl_s.br_wr;
  assign pc_en         = pc_write | (pc_write_cond & zero);
  assign pc_src        = ctl_s.pc_src;
  assign ir_write      = fetch_go_s;
  assign i_or_d        = ctl_s.i_or_d;
  assign mem_read      = ctl_s.mem_read;
  assign mem_write     = ctl_s.mem_write;
  assign reg_write     = ctl_s.reg_write;
  assign reg_dst       = ctl_s.reg_dst;
  assign mem_to_reg    = ctl_s.mem_to_reg;
  assign alu_src_a     = ctl_s.alu_src_a;
  assign alu_src_b     = ctl_s.alu_src_b;
  assign alu_ctr       = ctl_s.alu_ctr;
  assign ext_op        = ctl_s.ext_op;
  assign state         = state_q;
  assign illegal       = illegal_q & rst_n;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is expanded into its expected cycle sequence
// (with planned memory wait cycles) and every cycle's outputs are checked against it.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pc_write, pc_write_cond, pc_en, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_op, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctr;
  logic [3:0] state;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en), .pc_src(pc_src),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctr(alu_ctr), .ext_op(ext_op),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_en;
    logic [1:0] pc_src;
    logic       ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctr;
    logic       ext_op;
  } out_t;

  typedef struct { logic [3:0] st; logic mr; } step_t;

  step_t plan[$];
  int    n_chk = 0;
  int    n_pass = 0;
  logic  m_ill = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // outputs the specification demands for one cycle in a given state
  function automatic out_t exp_out(input logic [3:0] st, input logic mr, input logic z,
                                   input logic rs, input logic [5:0] fn);
    out_t o;
    o = '0;
    o.alu_ctr = 3'b010;
    o.ext_op  = 1'b1;
    if (!rs) begin
      case (st)
        4'd0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
        4'd1:  o.alu_src_b = 2'b11;
        4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
        4'd3:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
        4'd4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
        4'd5:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
        4'd6:  begin o.alu_src_a = 1'b1; o.alu_ctr = (fn == 6'b100011) ? 3'b110 : 3'b010; end
        4'd7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
        4'd8:  begin o.alu_src_a = 1'b1; o.alu_ctr = 3'b110; o.pc_write_cond = 1'b1; o.pc_src = 2'b01; end
        4'd9:  begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
        4'd10: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.ext_op = 1'b0; o.alu_ctr = 3'b001; end
        4'd11: o.reg_write = 1'b1;
        default: o.ext_op = 1'b1;
      endcase
    end
    o.pc_en = o.pc_write | (o.pc_write_cond & z);
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o = {pc_write, pc_write_cond, pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write,
         reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctr, ext_op};
    return o;
  endfunction

  // 0 R-type, 1 lw, 2 sw, 3 beq, 4 j, 5 ori, 6 illegal
  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) return ((f == 6'b100001) || (f == 6'b100011)) ? 0 : 6;
    else if (o == 6'b100011) return 1;
    else if (o == 6'b101011) return 2;
    else if (o == 6'b000100) return 3;
    else if (o == 6'b000010) return 4;
    else if (o == 6'b001101) return 5;
    else return 6;
  endfunction

  task automatic push_step(input logic [3:0] st, input logic mr);
    step_t s;
    s.st = st;
    s.mr = mr;
    plan.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // zf: 0 random zero, 1 zero held high, 2 zero held low; rst_at: step index that carries reset
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int fw, input int mw,
                           input int zf, input int rst_at, output int n_cyc, output int n_rw,
                           output int n_mem, output logic br_en, output logic [2:0] ie_alu);
    int   kind, n;
    step_t s;
    out_t e, a;
    logic z, rs;
    kind = kind_of(iop, ifn);
    plan.delete();
    for (int i = 0; i < fw; i++) push_step(4'd0, 1'b0);
    push_step(4'd0, 1'b1);
    push_step(4'd1, rbit());
    case (kind)
      0: begin push_step(4'd6, rbit()); push_step(4'd7, rbit()); end
      1: begin
        push_step(4'd2, rbit());
        for (int i = 0; i < mw; i++) push_step(4'd3, 1'b0);
        push_step(4'd3, 1'b1);
        push_step(4'd4, rbit());
      end
      2: begin
        push_step(4'd2, rbit());
        for (int i = 0; i < mw; i++) push_step(4'd5, 1'b0);
        push_step(4'd5, 1'b1);
      end
      3: push_step(4'd8, rbit());
      4: push_step(4'd9, rbit());
      5: begin push_step(4'd10, rbit()); push_step(4'd11, rbit()); end
      default: n = 0;
    endcase
    n = plan.size();
    if ((rst_at >= 0) && (rst_at < n)) n = rst_at + 1;
    n_cyc = 0; n_rw = 0; n_mem = 0; br_en = 1'b0; ie_alu = 3'b000;
    for (int i = 0; i < n; i++) begin
      s  = plan[i];
      rs = (i == rst_at);
      @(negedge clk);
      rst_n     = ~rs;
      mem_ready = s.mr;
      z         = (zf == 1) ? 1'b1 : (zf == 2) ? 1'b0 : rbit();
      zero      = z;
      if (s.st <= 4'd1) begin
        op = iop; funct = ifn;
      end else begin
        op = 6'($urandom); funct = 6'($urandom);
      end
      #1;
      e = exp_out(s.st, s.mr, z, rs, ifn);
      a = dut_out();
      check("outputs", 32'(a), 32'(e));
      check("state", 32'(state), 32'(s.st));
      check("illegal", 32'(illegal), 32'(m_ill & ~rs));
      n_cyc++;
      if (reg_write) n_rw++;
      if (mem_read & i_or_d) n_mem++;
      if (s.st == 4'd8) br_en = pc_en;
      if (s.st == 4'd10) ie_alu = alu_ctr;
      if (rs) m_ill = 1'b0;
      else if ((s.st == 4'd1) && (kind == 6)) m_ill = 1'b1;
    end
  endtask

  initial begin
    int nc, nrw, nm, k, fw, mw, ra;
    logic be;
    logic [2:0] ia;
    logic [5:0] ro, rf;

    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; op = 6'd0; funct = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_pc_en", 32'(pc_en), 32'd0);
    check("reset_outputs", 32'(dut_out()), 32'(exp_out(4'd0, 1'b1, 1'b1, 1'b1, 6'd0)));

    run_instr(6'b000000, 6'b100001, 0, 0, 0, -1, nc, nrw, nm, be, ia);
    check("addu_cycles", 32'(nc), 32'd4);
    check("addu_regwrite_cycles", 32'(nrw), 32'd1);
    run_instr(6'b100011, 6'b010101, 0, 2, 0, -1, nc, nrw, nm, be, ia);
    check("lw_cycles", 32'(nc), 32'd7);
    check("lw_memread_cycles", 32'(nm), 32'd3);
    run_instr(6'b000100, 6'b000000, 0, 0, 1, -1, nc, nrw, nm, be, ia);
    check("beq_cycles", 32'(nc), 32'd3);
    check("beq_taken_pc_en", 32'(be), 32'd1);
    run_instr(6'b000100, 6'b111111, 0, 0, 2, -1, nc, nrw, nm, be, ia);
    check("beq_not_taken_pc_en", 32'(be), 32'd0);
    run_instr(6'b001101, 6'b100011, 0, 0, 0, -1, nc, nrw, nm, be, ia);
    check("ori_cycles", 32'(nc), 32'd4);
    check("ori_alu_ctr", 32'(ia), 32'd1);
    run_instr(6'b000010, 6'b000000, 0, 0, 0, -1, nc, nrw, nm, be, ia);
    check("j_cycles", 32'(nc), 32'd3);
    run_instr(6'b101011, 6'b000000, 1, 1, 0, -1, nc, nrw, nm, be, ia);
    check("sw_waits_cycles", 32'(nc), 32'd6);
    run_instr(6'b000000, 6'b100011, 0, 0, 0, -1, nc, nrw, nm, be, ia);
    run_instr(6'b111111, 6'b000000, 0, 0, 0, -1, nc, nrw, nm, be, ia);
    check("illegal_cycles", 32'(nc), 32'd2);
    run_instr(6'b000000, 6'b100001, 0, 0, 0, -1, nc, nrw, nm, be, ia);
    check("illegal_sticky", 32'(illegal), 32'd1);
    run_instr(6'b101011, 6'b000000, 0, 5, 0, 5, nc, nrw, nm, be, ia);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    check("post_reset_state", 32'(state), 32'd0);
    check("post_reset_illegal", 32'(illegal), 32'd0);
    check("post_reset_mem_write", 32'(mem_write), 32'd0);

    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 7);
      rf = 6'($urandom);
      case (k)
        0: begin ro = 6'b000000; rf = 6'b100001; end
        1: begin ro = 6'b000000; rf = 6'b100011; end
        2: ro = 6'b100011;
        3: ro = 6'b101011;
        4: ro = 6'b000100;
        5: ro = 6'b000010;
        6: ro = 6'b001101;
        default: begin
          ro = 6'($urandom);
          if (kind_of(ro, rf) != 6) begin
            if (rbit()) begin ro = 6'b000000; rf = 6'b100000; end
            else ro = 6'b111111;
          end
        end
      endcase
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(ro, rf, fw, mw, 0, ra, nc, nrw, nm, be, ia);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
